// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: shared funct3 codes, FSM state encoding and funct3 legality helper
package lsu_mem_ctrl_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    return we ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_align: combinational lane steering for sub-word loads/stores
//  in : i_funct3, i_addr_lo (byte offset), i_load_word, i_store_data, i_old_word
//  out: o_load_data (extended), o_store_word (merged), o_misaligned
module lsu_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_load_word,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_old_word,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word,
  output logic        o_misaligned
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_bmask;
  logic [31:0] w_hmask;
  always_comb begin
    w_byte  = 8'(i_load_word >> {i_addr_lo, 3'b000});
    w_half  = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
    w_bmask = 32'h0000_00FF << {i_addr_lo, 3'b000};
    w_hmask = i_addr_lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    o_load_data = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                  (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                  (i_funct3 == F3_BU) ? {24'h0, w_byte} :
                  (i_funct3 == F3_HU) ? {16'h0, w_half} : i_load_word;
    // replicate the store data across all lanes, then let the mask pick the addressed one
    o_store_word = (i_funct3 == F3_B) ? (i_old_word & ~w_bmask) | ({4{i_store_data[7:0]}} & w_bmask) :
                   (i_funct3 == F3_H) ? (i_old_word & ~w_hmask) | ({2{i_store_data[15:0]}} & w_hmask) :
                   i_store_data;
    o_misaligned = (i_funct3[1:0] == 2'b01 && i_addr_lo[0]) || (i_funct3[1:0] == 2'b10 && i_addr_lo != 2'b00);
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store sequencer onto a word-only data memory (RMW for SB/SH)
//  req  : i_req_valid/o_req_ready, i_req_we, i_req_funct3, i_req_addr, i_req_wdata
//  resp : o_resp_valid/i_resp_ready, o_resp_rdata, o_resp_err
//  mem  : o_mem_we, o_mem_addr (word aligned), o_mem_wdata, i_mem_rdata (combinational read)
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int MEM_SIZE = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);
  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_idle;
  logic        w_accept;
  logic        w_fault;
  logic        w_misaligned;
  logic [2:0]  w_f3;
  logic [1:0]  w_alo;
  logic [31:0] w_load;
  logic [31:0] w_store;
  assign w_idle   = r_state == ST_IDLE;
  assign w_accept = w_idle && i_req_valid;
  // one aligner serves both the accept-time misalignment check and the later data steering
  assign w_f3  = w_idle ? i_req_funct3 : r_f3;
  assign w_alo = w_idle ? i_req_addr[1:0] : r_addr[1:0];
  assign w_fault = !f3_legal(i_req_we, i_req_funct3) || w_misaligned ||
                   ({2'b00, i_req_addr[31:2]} >= MEM_SIZE);
  lsu_align u_align (
    .i_funct3    (w_f3),
    .i_addr_lo   (w_alo),
    .i_load_word (i_mem_rdata),
    .i_store_data(r_wdata),
    .i_old_word  (r_word),
    .o_load_data (w_load),
    .o_store_word(w_store),
    .o_misaligned(w_misaligned)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = !i_req_valid ? ST_IDLE : w_fault ? ST_RESP :
                         (i_req_we && i_req_funct3 == F3_W) ? ST_WRITE : ST_READ;
      ST_READ:  w_next = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      default:  w_next = i_resp_ready ? ST_IDLE : ST_RESP;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= i_req_we;
        r_f3    <= i_req_funct3;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_err   <= w_fault;
        r_rdata <= '0;
      end
      // READ captures the old word for RMW stores and the extended result for loads
      if (r_state == ST_READ) begin
        r_word <= i_mem_rdata;
        if (!r_we) r_rdata <= w_load;
      end
      if (r_state == ST_RESP && i_resp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end
  assign o_req_ready  = w_idle || !i_rst_n;
  assign o_resp_valid = r_state == ST_RESP;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_mem_we     = (r_state == ST_WRITE) && i_rst_n;
  assign o_mem_addr   = {r_addr[31:2], 2'b00};
  assign o_mem_wdata  = (r_state == ST_WRITE) ? w_store : '0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of lsu_mem_ctrl against a preloaded word memory
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [0:1023];
  int          we_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;
  int          total = 0;
  int          passed = 0;
  always #5 clk = ~clk;
  lsu_mem_ctrl #(.MEM_SIZE(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_rdata(resp_rdata),
    .o_resp_err(resp_err), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );
  assign mem_rdata = (mem_addr[31:12] == 20'h0) ? mem[mem_addr[11:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr[31:12] == 20'h0) mem[mem_addr[11:2]] <= mem_wdata;
      we_cnt++;
      last_wdata = mem_wdata;
      last_waddr = mem_addr;
    end
  end
  // issue one request from IDLE with resp_ready=1; lat is the T+n response cycle (99 on timeout)
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
    total++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got %b want 0", resp_err); else passed++;
    total++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready got %b want 1", req_ready); else passed++;
  endtask
  task automatic test_load();
    int lat; logic [31:0] rd; logic er; int n0;
    n0 = we_cnt;
    issue(1'b0, 3'b010, 32'h08, 32'h0, lat, rd, er);
    total++; if (lat !== 2) $display("FAIL lw_latency got %0d want 2", lat); else passed++;
    total++; if (rd !== 32'h2) $display("FAIL lw_rdata got %h want 00000002", rd); else passed++;
    total++; if (er !== 1'b0) $display("FAIL lw_err got %b want 0", er); else passed++;
    total++; if (we_cnt !== n0) $display("FAIL lw_mem_we got %0d writes want 0", we_cnt - n0); else passed++;
  endtask
  task automatic test_subword_store();
    int lat; logic [31:0] rd; logic er; int n0;
    n0 = we_cnt;
    issue(1'b1, 3'b000, 32'h11, 32'h0000_00AA, lat, rd, er);
    total++; if (lat !== 3) $display("FAIL sb_latency got %0d want 3", lat); else passed++;
    total++; if (we_cnt - n0 !== 1) $display("FAIL sb_write_count got %0d want 1", we_cnt - n0); else passed++;
    total++; if (last_wdata !== 32'h0000_AA04) $display("FAIL sb_mem_wdata got %h want 0000aa04", last_wdata); else passed++;
    total++; if (last_waddr !== 32'h10) $display("FAIL sb_mem_addr got %h want 00000010", last_waddr); else passed++;
    total++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sb_resp got rdata %h err %b want 0 0", rd, er); else passed++;
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    total++; if (rd !== 32'h0000_AA04) $display("FAIL sb_readback got %h want 0000aa04", rd); else passed++;
    issue(1'b1, 3'b001, 32'h22, 32'hFFFF_1234, lat, rd, er);
    total++; if (lat !== 3) $display("FAIL sh_latency got %0d want 3", lat); else passed++;
    total++; if (mem[8] !== 32'h1234_0008) $display("FAIL sh_merge got %h want 12340008", mem[8]); else passed++;
  endtask
  task automatic test_store_word();
    int lat; logic [31:0] rd; logic er; int n0;
    n0 = we_cnt;
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
    total++; if (lat !== 2) $display("FAIL sw_latency got %0d want 2", lat); else passed++;
    total++; if (we_cnt - n0 !== 1) $display("FAIL sw_write_count got %0d want 1", we_cnt - n0); else passed++;
    total++; if (last_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_mem_wdata got %h want deadbeef", last_wdata); else passed++;
    issue(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er);
    total++; if (rd !== 32'hFFFF_FFDE) $display("FAIL lb_0x13 got %h want ffffffde", rd); else passed++;
    issue(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, er);
    total++; if (rd !== 32'h0000_00DE) $display("FAIL lbu_0x13 got %h want 000000de", rd); else passed++;
    issue(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, er);
    total++; if (rd !== 32'hFFFF_DEAD) $display("FAIL lh_0x12 got %h want ffffdead", rd); else passed++;
    issue(1'b0, 3'b101, 32'h10, 32'h0, lat, rd, er);
    total++; if (rd !== 32'h0000_BEEF) $display("FAIL lhu_0x10 got %h want 0000beef", rd); else passed++;
    issue(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, er);
    total++; if (rd !== 32'hFFFF_FFBE) $display("FAIL lb_0x11 got %h want ffffffbe", rd); else passed++;
  endtask
  task automatic test_faults();
    logic [31:0] fa [5] = '{32'h05, 32'h0E, 32'h00, 32'h1000, 32'h04};
    logic [2:0]  ff [5] = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b100};
    logic        fw [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat; logic [31:0] rd; logic er; int n0;
    n0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      issue(fw[i], ff[i], fa[i], 32'hCAFE_F00D, lat, rd, er);
      total++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0)
        $display("FAIL fault_%0d got lat %0d err %b rdata %h want 1 1 00000000", i, lat, er, rd); else passed++;
    end
    total++; if (we_cnt !== n0) $display("FAIL fault_mem_we got %0d writes want 0", we_cnt - n0); else passed++;
    total++; if (mem[3] !== 32'h3 || mem[1] !== 32'h1)
      $display("FAIL fault_mem_unchanged got %h %h want 00000003 00000001", mem[3], mem[1]); else passed++;
  endtask
  task automatic test_hold();
    int n0;
    n0 = we_cnt;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0C;
    @(posedge clk); #1;
    req_addr = 32'h08;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b1) $display("FAIL hold_valid_start got %b want 1", resp_valid); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h3 || req_ready !== 1'b0)
        $display("FAIL hold_cycle_%0d got valid %b rdata %h ready %b want 1 00000003 0", i, resp_valid, resp_rdata, req_ready);
      else passed++;
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    total++; if (req_ready !== 1'b0) $display("FAIL handshake_req_ready got %b want 0", req_ready); else passed++;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL after_resp got valid %b ready %b want 0 1", resp_valid, req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h2)
      $display("FAIL queued_load got valid %b rdata %h want 1 00000002", resp_valid, resp_rdata); else passed++;
    @(posedge clk); #1;
    total++; if (we_cnt !== n0) $display("FAIL hold_mem_we got %0d writes want 0", we_cnt - n0); else passed++;
  endtask
  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; int n0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h25; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_we !== 1'b1) $display("FAIL mid_in_write got mem_we %b want 1", mem_we); else passed++;
    n0 = we_cnt;
    rst_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL mid_we_gated got %b want 0", mem_we); else passed++;
    @(posedge clk); #1;
    total++; if (we_cnt !== n0 || resp_valid !== 1'b0)
      $display("FAIL mid_abort got writes %0d valid %b want 0 0", we_cnt - n0, resp_valid); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL mid_release got ready %b valid %b want 1 0", req_ready, resp_valid); else passed++;
    total++; if (mem[9] !== 32'h9) $display("FAIL mid_mem_unchanged got %h want 00000009", mem[9]); else passed++;
    issue(1'b0, 3'b010, 32'h24, 32'h0, lat, rd, er);
    total++; if (lat !== 2 || rd !== 32'h9) $display("FAIL mid_readback got lat %0d rdata %h want 2 00000009", lat, rd); else passed++;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    test_reset();
    test_load();
    test_subword_store();
    test_store_word();
    test_faults();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
